mem_access: RTL
===============

Name: mem_access

Overview:
- Memory stage directly downstream of the execute stage.
- Consumes the execute result (destination register, write enable, ALU data) plus a load/store request.
- Performs the access over a byte-wide single-port RAM, then hands one registered result per instruction to the write-back side.
- Holds the pipeline through stall_req_o while a multi-byte access is in flight.

Parameters:
- RAM_LAT, 1, cycles from ram_addr_o presented to ram_din_i valid (fixed at 1 for this revision).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- valid_i  in  1  execute result present this cycle
- ready_o  out  1  stage can accept; high only in IDLE
- wd_i  in  5  destination register address
- wreg_i  in  1  destination write enable
- wdata_i  in  32  ALU result
- mem_op_i  in  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE
- mem_addr_i  in  32  byte address
- mem_wdata_i  in  32  store data
- flush_i  in  1  synchronous flush request from pipeline control
- ram_addr_o  out  32  RAM byte address
- ram_wr_o  out  1  RAM write strobe
- ram_dout_o  out  8  RAM write byte
- ram_din_i  in  8  RAM read byte
- valid_o  out  1  one-cycle result pulse to write-back
- wd_o  out  5  destination register address
- wreg_o  out  1  destination write enable
- wdata_o  out  32  result data
- stall_req_o  out  1  high whenever state != IDLE

Behaviour:
- Reset values, applied asynchronously while rst=0: all outputs 0 except ready_o=1; state IDLE; byte counter 0. ram_wr_o drops immediately, including mid-access.
- Byte count n: 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW.
- Byte order is little-endian. Byte k uses address mem_addr_i+k, wrapping mod 2^32. Misaligned addresses are legal; no exception is raised.
- Accept at edge E0: valid_i=1, ready_o=1, flush_i=0. Inputs are captured at E0. Cycle c means the c-th cycle after E0.
- NONE op: state stays IDLE. In cycle 1: valid_o=1, wd/wreg/wdata equal the captured inputs.
- Store: state STORE for cycles 1..n. In cycle k+1: ram_addr_o=addr+k, ram_wr_o=1, ram_dout_o=wdata[8k+7:8k]. In cycle n+1: state IDLE, valid_o=1, wreg_o=0, wdata_o=0.
- Load, address phase: state LOAD presents addr+k in cycle k+1 (k=0..n-1).
- Load, data phase: ram_din_i for byte k is sampled at the end of cycle k+2; state WAIT covers cycle n+1.
- Load, result: in cycle n+2, state IDLE, valid_o=1, wd_o/wreg_o from capture, wdata_o = assembled value. LB/LH sign-extend; LBU/LHU zero-extend; LW uses all 32 bits.
- ram_wr_o=0 whenever not in STORE. ram_addr_o holds its last value when idle.
- valid_o is high for exactly one cycle per accepted instruction. Outside that cycle, wd_o/wreg_o/wdata_o are 0.
- Back-to-back: ready_o is high in the cycle valid_o is high, so a new instruction may be accepted at that cycle's closing edge.
- flush_i in IDLE: the input is not accepted.
- flush_i during LOAD/WAIT: return to IDLE next edge, no valid_o, partial data discarded.
- flush_i during STORE: ignored; the store completes and valid_o is still produced, so memory is never left partially written.
- valid_i while ready_o=0: ignored. Upstream holds via stall_req_o.

Test Plan:
- Reset mid-store: SW addr 0x100 data 0xDEADBEEF, rst=0 in cycle 2 -> ram_wr_o=0 immediately; after release, state IDLE, ready_o=1, no valid_o.
- Pass-through: NONE, wd=5, wreg=1, wdata=0x1234 -> cycle 1: valid_o=1, wd_o=5, wdata_o=0x1234; no ram_wr_o.
- SW addr 0xFFFFFFFE data 0x11223344 -> writes 0x44@FFFFFFFE, 0x33@FFFFFFFF, 0x22@0, 0x11@1 in cycles 1-4; valid_o in cycle 5 with wreg_o=0; stall_req_o high cycles 1-4.
- LB vs LBU, RAM byte 0x80 at 0x20 -> LB wdata_o=0xFFFFFF80, LBU wdata_o=0x00000080, both in cycle 3. LH at 0x21 with bytes 0x34,0x12 -> 0x00001234 in cycle 4.
- Flush: flush_i during LW cycle 2 -> no valid_o, IDLE at cycle 3. Flush during SH cycle 1 -> both bytes written, valid_o in cycle 3.
- Back-to-back: LW then NONE -> NONE accepted at the end of the LW valid_o cycle (cycle 6); its valid_o follows in cycle 7.

Source files
------------

// File: rtl/mem_access.sv
// Byte-serial load/store stage over a 1-cycle-latency byte RAM. Results take 1 (NONE), n+1 (store) or n+2 (load) cycles.
// ready_o is high only when idle and stall_req_o holds upstream; valid_i while busy is dropped.
module mem_access #(
  parameter int unsigned RAM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        flush_i,
  output logic [31:0] ram_addr_o,
  output logic        ram_wr_o,
  output logic [7:0]  ram_dout_o,
  input  logic [7:0]  ram_din_i,
  output logic        valid_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stall_req_o
);

  localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4,
                         OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, STORE} state_t;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [3:0]  op;
    logic [31:0] sdata;
  } req_t;

  function automatic logic [2:0] op_bytes(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_bytes = 3'd1;
      OP_LH, OP_LHU, OP_SH: op_bytes = 3'd2;
      OP_LW, OP_SW:         op_bytes = 3'd4;
      default:              op_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    is_load = (op >= OP_LB) && (op <= OP_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    is_store = (op >= OP_SB) && (op <= OP_SW);
  endfunction

  state_t      state_q, state_d;
  req_t        req_q;
  logic [2:0]  cnt_q;
  logic [31:0] ldata_q, ldata_nx, ld_result;
  logic [2:0]  n_q;
  logic        last, accept, sample;
  logic [1:0]  rd_idx;

  assign ready_o     = (state_q == IDLE);
  assign stall_req_o = (state_q != IDLE);
  assign accept      = valid_i && ready_o && !flush_i;
  assign n_q         = op_bytes(req_q.op);
  assign last        = (cnt_q == n_q - 3'd1);
  assign ram_wr_o    = (state_q == STORE);
  assign ram_dout_o  = ram_wr_o ? req_q.sdata[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;

  // Read data trails the address counter by the RAM latency; WAIT catches the final byte.
  assign sample = ((state_q == LOAD) || (state_q == WAIT)) && (cnt_q >= 3'(RAM_LAT));
  assign rd_idx = 2'(cnt_q - 3'(RAM_LAT));

  always_comb begin
    ldata_nx = ldata_q;
    if (sample) ldata_nx[{rd_idx, 3'b000} +: 8] = ram_din_i;
  end

  always_comb begin
    case (req_q.op)
      OP_LB:   ld_result = {{24{ldata_nx[7]}}, ldata_nx[7:0]};
      OP_LH:   ld_result = {{16{ldata_nx[15]}}, ldata_nx[15:0]};
      OP_LBU:  ld_result = {24'd0, ldata_nx[7:0]};
      OP_LHU:  ld_result = {16'd0, ldata_nx[15:0]};
      default: ld_result = ldata_nx;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_load(mem_op_i))       state_d = LOAD;
          else if (is_store(mem_op_i)) state_d = STORE;
        end
      end
      LOAD: begin
        if (flush_i)   state_d = IDLE;
        else if (last) state_d = WAIT;
      end
      WAIT:    state_d = IDLE;
      STORE:   if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      req_q      <= '0;
      cnt_q      <= 3'd0;
      ldata_q    <= 32'd0;
      ram_addr_o <= 32'd0;
      valid_o    <= 1'b0;
      wd_o       <= 5'd0;
      wreg_o     <= 1'b0;
      wdata_o    <= 32'd0;
    end else begin
      state_q <= state_d;
      valid_o <= 1'b0;
      wd_o    <= 5'd0;
      wreg_o  <= 1'b0;
      wdata_o <= 32'd0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_q   <= '{wd: wd_i, wreg: wreg_i, op: mem_op_i, sdata: mem_wdata_i};
            cnt_q   <= 3'd0;
            ldata_q <= 32'd0;
            if (is_load(mem_op_i) || is_store(mem_op_i)) begin
              ram_addr_o <= mem_addr_i;
            end else begin
              valid_o <= 1'b1;
              wd_o    <= wd_i;
              wreg_o  <= wreg_i;
              wdata_o <= wdata_i;
            end
          end
        end
        LOAD: begin
          if (!flush_i) begin
            ldata_q <= ldata_nx;
            cnt_q   <= cnt_q + 3'd1;
            if (!last) ram_addr_o <= ram_addr_o + 32'd1;
          end
        end
        WAIT: begin
          if (!flush_i) begin
            valid_o <= 1'b1;
            wd_o    <= req_q.wd;
            wreg_o  <= req_q.wreg;
            wdata_o <= ld_result;
          end
        end
        STORE: begin
          // Flush is deliberately ignored so memory is never left half-written.
          cnt_q <= cnt_q + 3'd1;
          if (last) begin
            valid_o <= 1'b1;
            wd_o    <= req_q.wd;
          end else begin
            ram_addr_o <= ram_addr_o + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
